// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - two-client byte sequencer driving the APB port of an SPI core
//
// Purpose: programs CR1/CR2/BR after reset. It then grants byte transfers to client 0 or
// client 1 in round-robin order. For each granted byte it polls SR for SPTEF, writes DR,
// polls SR for SPIF and reads DR. The received byte is returned with a one-cycle ack.
//
// Ports:
//   pclk, preset              clock, synchronous active-high reset
//   req0/1, wdata0/1          client requests and bytes to send
//   ack0/1, rdata, err        completion pulse, received byte, error flag (valid with ack)
//   cfg_done, busy            configuration finished, FSM not in IDLE
//   paddr..pwdata             APB master outputs
//   prdata, pready, pslverr   APB responses
module spi_xfer_sequencer #(
    parameter logic [7:0] CFG_CR1  = 8'h50,
    parameter logic [7:0] CFG_CR2  = 8'h00,
    parameter logic [7:0] CFG_BR   = 8'h00,
    parameter int         POLL_MAX = 1023
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       cfg_done,
    output logic       busy,
    output logic [2:0] paddr,
    output logic       pwrite,
    output logic       psel,
    output logic       penable,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);
    localparam logic [2:0] A_CR1 = 3'd0;
    localparam logic [2:0] A_CR2 = 3'd1;
    localparam logic [2:0] A_BR  = 3'd2;
    localparam logic [2:0] A_SR  = 3'd3;
    localparam logic [2:0] A_DR  = 3'd5;
    localparam logic [9:0] L_POLL_MAX = 10'(POLL_MAX);

    typedef enum logic [3:0] {
        S_CFG1, S_CFG2, S_CFG3, S_IDLE, S_POLL_TX, S_WR_DR, S_POLL_RX, S_RD_DR, S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_psel, r_penable, r_pwrite;
    logic [2:0] r_paddr;
    logic [7:0] r_pwdata;
    logic       r_ack0, r_ack1, r_err, r_cfg_done;
    logic [7:0] r_rdata;
    logic       r_last;      // client granted most recently
    logic       r_id;        // client owning the current transfer
    logic [7:0] r_xfer;      // byte latched at grant
    logic       r_err_flag;  // sticky pslverr for the current transfer
    logic [9:0] r_cnt;       // failed SR reads in the current poll state
    logic       w_done, w_setup, w_timeout, w_abort, w_grant, w_pick;

    function automatic logic [2:0] f_addr(input state_t s);
        case (s)
            S_CFG1:              return A_CR1;
            S_CFG2:              return A_CR2;
            S_CFG3:              return A_BR;
            S_POLL_TX, S_POLL_RX: return A_SR;
            default:             return A_DR;
        endcase
    endfunction

    function automatic logic [7:0] f_wdata(input state_t s, input logic [7:0] xfer);
        case (s)
            S_CFG1:  return CFG_CR1;
            S_CFG2:  return CFG_CR2;
            S_CFG3:  return CFG_BR;
            S_WR_DR: return xfer;
            default: return 8'h00;
        endcase
    endfunction

    // w_setup means the cycle after this edge is the SETUP of a fresh access for w_next,
    // so completions chain straight into the next access without an idle cycle.
    always_comb begin
        w_done    = r_psel & r_penable & pready;
        w_timeout = (r_cnt + 10'd1) == L_POLL_MAX;
        w_grant   = (r_state == S_IDLE) & r_cfg_done & (req0 | req1);
        w_pick    = (req0 & req1) ? ~r_last : req1;
        w_next    = r_state;
        w_setup   = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            S_CFG1, S_CFG2: begin
                if (!r_psel) begin
                    w_setup = 1'b1;
                end else if (w_done) begin
                    w_next  = (r_state == S_CFG1) ? S_CFG2 : S_CFG3;
                    w_setup = 1'b1;
                end
            end
            S_CFG3: begin
                if (!r_psel)     w_setup = 1'b1;
                else if (w_done) w_next  = S_IDLE;
            end
            S_IDLE: begin
                if (w_grant) begin
                    w_next  = S_POLL_TX;
                    w_setup = 1'b1;
                end
            end
            S_POLL_TX: begin
                if (w_done) begin
                    if (prdata[5]) begin
                        w_next  = S_WR_DR;
                        w_setup = 1'b1;
                    end else if (w_timeout) begin
                        w_next  = S_DONE;
                        w_abort = 1'b1;
                    end else begin
                        w_setup = 1'b1;
                    end
                end
            end
            S_WR_DR: begin
                if (w_done) begin
                    w_next  = S_POLL_RX;
                    w_setup = 1'b1;
                end
            end
            S_POLL_RX: begin
                if (w_done) begin
                    if (prdata[7]) begin
                        w_next  = S_RD_DR;
                        w_setup = 1'b1;
                    end else if (w_timeout) begin
                        w_next  = S_DONE;
                        w_abort = 1'b1;
                    end else begin
                        w_setup = 1'b1;
                    end
                end
            end
            S_RD_DR: begin
                if (w_done) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_CFG1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_CFG1;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= 3'd0;
            r_pwdata   <= 8'h00;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err      <= 1'b0;
            r_cfg_done <= 1'b0;
            r_rdata    <= 8'h00;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_xfer     <= 8'h00;
            r_err_flag <= 1'b0;
            r_cnt      <= 10'd0;
        end else begin
            r_state <= w_next;

            if (w_setup) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_paddr   <= f_addr(w_next);
                r_pwrite  <= (w_next inside {S_CFG1, S_CFG2, S_CFG3, S_WR_DR});
                r_pwdata  <= f_wdata(w_next, r_xfer);
            end else if (r_psel && !r_penable) begin
                r_penable <= 1'b1;
            end else if (w_done) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end

            if (r_state == S_CFG3 && w_done) r_cfg_done <= 1'b1;

            if (w_grant) begin
                r_id       <= w_pick;
                r_last     <= w_pick;
                r_xfer     <= w_pick ? wdata1 : wdata0;
                r_err_flag <= 1'b0;
            end else if (w_done && pslverr &&
                         (r_state inside {S_POLL_TX, S_WR_DR, S_POLL_RX, S_RD_DR})) begin
                r_err_flag <= 1'b1;
            end

            if (w_next != r_state) begin
                r_cnt <= 10'd0;
            end else if (w_done && (r_state inside {S_POLL_TX, S_POLL_RX})) begin
                r_cnt <= r_cnt + 10'd1;
            end

            if (r_state == S_RD_DR && w_done) r_rdata <= prdata;

            // The error seen on the very access that ends the transfer is folded in here.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_ack0 <= ~r_id;
                r_ack1 <= r_id;
                r_err  <= r_err_flag | (w_done & pslverr) | w_abort;
            end
        end
    end

    assign psel     = r_psel;
    assign penable  = r_penable;
    assign pwrite   = r_pwrite;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata    = r_rdata;
    assign err      = r_err;
    assign cfg_done = r_cfg_done;
    assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - self-checking bench for spi_xfer_sequencer
module tb_spi_xfer_sequencer;
    localparam int         PM     = 4;
    localparam logic [7:0] T_CR1  = 8'h50;
    localparam logic [7:0] T_CR2  = 8'h00;
    localparam logic [7:0] T_BR   = 8'h12;

    typedef struct {
        int         id;
        logic [7:0] wd;
        int         waits;
        int         tx_fail;
        int         rx_fail;
        bit         zero_sr;
        bit         wr_err;
        logic [7:0] dr;
        bit         exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        bit         id;
        logic [7:0] rd;
        bit         er;
    } ack_t;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1, err, cfg_done, busy, pwrite, psel, penable;
    logic [7:0] rdata, pwdata;
    logic [2:0] paddr;
    logic [7:0] prdata = 8'h00;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int         waits = 0;
    int         wcnt = 0;
    bit         slverr_any = 0;
    bit         slverr_wr = 0;
    logic [7:0] dr_val = 8'h00;
    int         dr_cnt = 0;
    logic [7:0] sr_q[$];
    acc_t       exp_acc[$];
    ack_t       exp_ack[$];

    acc_t       m_acc;
    ack_t       m_ack;
    logic [2:0] s_addr;
    logic       s_wr;
    logic [7:0] s_wd;

    vec_t vt[7];

    spi_xfer_sequencer #(
        .CFG_CR1 (T_CR1),
        .CFG_CR2 (T_CR2),
        .CFG_BR  (T_BR),
        .POLL_MAX(PM)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .req0    (req0),
        .req1    (req1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata   (rdata),
        .err     (err),
        .cfg_done(cfg_done),
        .busy    (busy),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    function automatic acc_t mk_acc(input bit wr, input logic [2:0] a, input logic [7:0] d);
        acc_t r;
        r.wr = wr;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic ack_t mk_ack(input bit id, input logic [7:0] rd, input bit er);
        ack_t r;
        r.id = id;
        r.rd = rd;
        r.er = er;
        return r;
    endfunction

    // APB slave, access scoreboard and ack scoreboard, all evaluated away from the active edge.
    always @(negedge pclk) begin
        if (psel && !penable) begin
            s_addr = paddr;
            s_wr   = pwrite;
            s_wd   = pwdata;
        end else if (psel && penable) begin
            chk("apb_stable", 32'({pwrite, paddr, pwdata}), 32'({s_wr, s_addr, s_wd}));
        end

        pslverr = 1'b0;
        if (psel && penable) begin
            if (wcnt < waits) begin
                pready = 1'b0;
                wcnt++;
            end else begin
                pready = 1'b1;
                if (paddr == 3'd3 && !pwrite) begin
                    if (sr_q.size() > 0) prdata = sr_q.pop_front();
                    else                 prdata = 8'h00;
                end else if (paddr == 3'd5 && !pwrite) begin
                    prdata = dr_val ^ 8'(dr_cnt);
                    dr_cnt++;
                end else begin
                    prdata = 8'h00;
                end
                pslverr = slverr_any || (slverr_wr && paddr == 3'd5 && pwrite);
                if (exp_acc.size() == 0) begin
                    fail("unexpected_access");
                end else begin
                    m_acc = exp_acc.pop_front();
                    chk("acc_kind", 32'({pwrite, paddr}), 32'({m_acc.wr, m_acc.addr}));
                    if (m_acc.wr) chk("acc_wdata", 32'(pwdata), 32'(m_acc.data));
                end
            end
        end else begin
            pready = 1'b0;
            wcnt = 0;
        end

        if (ack0 || ack1) begin
            chk("ack_overlap", 32'(ack0 & ack1), 32'd0);
            if (exp_ack.size() == 0) begin
                fail("unexpected_ack");
            end else begin
                m_ack = exp_ack.pop_front();
                chk("ack_id", 32'(ack1), 32'(m_ack.id));
                chk("ack_rdata", 32'(rdata), 32'(m_ack.rd));
                chk("ack_err", 32'(err), 32'(m_ack.er));
            end
        end
    end

    task automatic push_cfg();
        exp_acc.push_back(mk_acc(1'b1, 3'd0, T_CR1));
        exp_acc.push_back(mk_acc(1'b1, 3'd1, T_CR2));
        exp_acc.push_back(mk_acc(1'b1, 3'd2, T_BR));
    endtask

    // Called at a negedge in an IDLE cycle; returns at a negedge in the next IDLE cycle.
    task automatic run_vec(input vec_t v);
        int g;
        int n;
        bit ok;
        waits = v.waits;
        slverr_wr = v.wr_err;
        dr_val = v.dr;
        dr_cnt = 0;
        n = (v.tx_fail < PM) ? v.tx_fail : PM;
        for (int i = 0; i < n; i++) begin
            sr_q.push_back(v.zero_sr ? 8'h00 : 8'h80);
            exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
        end
        if (v.tx_fail < PM) begin
            sr_q.push_back(8'h20);
            exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
            exp_acc.push_back(mk_acc(1'b1, 3'd5, v.wd));
            n = (v.rx_fail < PM) ? v.rx_fail : PM;
            for (int i = 0; i < n; i++) begin
                sr_q.push_back(v.zero_sr ? 8'h00 : 8'h20);
                exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
            end
            if (v.rx_fail < PM) begin
                sr_q.push_back(8'h80);
                exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
                exp_acc.push_back(mk_acc(1'b0, 3'd5, 8'h00));
            end
        end
        exp_ack.push_back(mk_ack(v.id[0], v.exp_rd, v.exp_err));
        wdata0 = (v.id == 0) ? v.wd : ~v.wd;
        wdata1 = (v.id == 1) ? v.wd : ~v.wd;
        req0 = (v.id == 0);
        req1 = (v.id == 1);
        g = cyc + 1;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge pclk);
            if (ack0 || ack1) ok = 1;
        end
        if (!ok) fail("ack_timeout");
        else     chk("ack_latency", 32'(cyc - g), 32'(v.exp_lat));
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge pclk);
        chk("idle_after_ack", 32'(busy), 32'd0);
        chk("acc_drained", 32'(exp_acc.size()), 32'd0);
        exp_acc.delete();
        sr_q.delete();
        exp_ack.delete();
    endtask

    task automatic check_cfg_phase();
        for (int k = 1; k <= 7; k++) begin
            @(negedge pclk);
            chk("cfg_done_timing", 32'(cfg_done), 32'(k >= 7));
        end
    endtask

    initial begin
        int got;
        int last_c;
        int g;
        vt[0] = '{0, 8'hA5, 0, 0, 0, 0, 0, 8'h3C, 0, 8'h3C, 8};
        vt[1] = '{1, 8'h5A, 0, 3, 0, 0, 0, 8'h81, 0, 8'h81, 14};
        vt[2] = '{0, 8'h0F, 3, 0, 3, 0, 0, 8'h77, 0, 8'h77, 35};
        vt[3] = '{1, 8'hF0, 0, 0, 0, 0, 1, 8'h99, 1, 8'h99, 8};
        vt[4] = '{0, 8'h11, 0, 4, 0, 1, 0, 8'hEE, 1, 8'h99, 8};
        vt[5] = '{0, 8'h22, 1, 0, 4, 0, 0, 8'hEE, 1, 8'h99, 18};
        vt[6] = '{1, 8'hC3, 2, 1, 1, 0, 0, 8'h5E, 0, 8'h5E, 24};

        repeat (3) @(negedge pclk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        push_cfg();
        preset = 1'b0;
        check_cfg_phase();
        chk("cfg_accesses", 32'(exp_acc.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("idle_no_psel", 32'({psel, busy}), 32'd0);
        end

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Round-robin with both clients always requesting; last grant above was client 1.
        waits = 0;
        slverr_wr = 0;
        dr_val = 8'h40;
        dr_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            sr_q.push_back(8'h20);
            sr_q.push_back(8'h80);
            exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
            exp_acc.push_back(mk_acc(1'b1, 3'd5, (k % 2 == 1) ? 8'h62 : 8'h31));
            exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
            exp_acc.push_back(mk_acc(1'b0, 3'd5, 8'h00));
            exp_ack.push_back(mk_ack(k % 2 == 1, 8'h40 ^ 8'(k), 1'b0));
        end
        wdata0 = 8'h31;
        wdata1 = 8'h62;
        req0 = 1'b1;
        req1 = 1'b1;
        got = 0;
        last_c = 0;
        for (int t = 0; t < 400 && got < 4; t++) begin
            @(negedge pclk);
            if (ack0 || ack1) begin
                got++;
                if (got > 1) chk("rr_ack_spacing", 32'(cyc - last_c), 32'd10);
                last_c = cyc;
                if (got == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        if (got < 4) fail("rr_ack_timeout");
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge pclk);
        chk("rr_drained", 32'(exp_acc.size() + exp_ack.size()), 32'd0);
        exp_acc.delete();
        exp_ack.delete();
        sr_q.delete();

        // Reset during POLL_RX: no ack, APB dropped, configuration redone.
        sr_q.push_back(8'h20);
        sr_q.push_back(8'h20);
        sr_q.push_back(8'h20);
        exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
        exp_acc.push_back(mk_acc(1'b1, 3'd5, 8'h66));
        exp_acc.push_back(mk_acc(1'b0, 3'd3, 8'h00));
        wdata0 = 8'h66;
        req0 = 1'b1;
        g = cyc + 1;
        while (cyc < g + 5) @(negedge pclk);
        chk("pre_reset_rx_poll", 32'({psel, penable, pwrite, paddr}), 32'({1'b1, 1'b1, 1'b0, 3'd3}));
        preset = 1'b1;
        @(negedge pclk);
        chk("mid_rst_psel", 32'({psel, penable}), 32'd0);
        chk("mid_rst_ack", 32'({ack0, ack1}), 32'd0);
        chk("mid_rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        exp_acc.delete();
        sr_q.delete();
        slverr_any = 1'b1;
        push_cfg();
        req0 = 1'b0;
        preset = 1'b0;
        check_cfg_phase();
        chk("recfg_accesses", 32'(exp_acc.size()), 32'd0);
        slverr_any = 1'b0;
        run_vec('{1, 8'h77, 0, 0, 0, 0, 0, 8'h1B, 0, 8'h1B, 8});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
